m_led_sequencer: RTL and testbench
==================================

// Module: m_led_sequencer
// PURPOSE
//  Downstream consumer of the one-cycle tick produced by the 100M-cycle divider stage on the
//  clocking-wizard clock. Advances a selectable LED pattern once per tick and applies PWM brightness
//  before driving the board LEDs and VIO probes. Replaces the fixed all-LEDs toggle with mode-driven sequencing.
// PARAMETERS
//  NLED    4  number of LEDs driven; legal range 2..8
//  DUTY_W  8  PWM counter/duty width; PWM period = 2**DUTY_W cycles
// PORTS
//  w_clk    in   1       single clock (clocking-wizard output domain)
//  w_rst_n  in   1       asynchronous, active-low reset
//  w_tick   in   1       one-cycle strobe from divider; one pattern step per strobe
//  w_en     in   1       1 = run; 0 = freeze pattern, ignore ticks, blank LEDs
//  w_mode   in   2       0 BLINK, 1 SHIFT, 2 BOUNCE, 3 COUNT
//  w_duty   in   DUTY_W  brightness; 0 = off, all-ones = fully on
//  w_led    out  NLED    registered LED drive
//  w_step   out  1       one-cycle pulse, registered, asserted the cycle after each pattern advance
// BEHAVIOUR
//  Reset (async assert, sync deassert use of w_rst_n): r_mode=BLINK, r_pat=0, r_dir=UP, r_pwm=0,
//   r_duty=0, w_led=0, w_step=0. Reset mid-operation discards all state immediately.
//  Step (w_en=1 && w_tick=1):
//   - if w_mode != r_mode: r_mode<=w_mode, r_pat<=seed(w_mode), r_dir<=UP; counts as an advance.
//     Seeds: BLINK all-ones, SHIFT 1, BOUNCE 1, COUNT 0.
//   - else advance per r_mode:
//     BLINK: r_pat <= ~r_pat.
//     SHIFT: rotate left by 1; MSB wraps to bit 0.
//     BOUNCE: FSM {UP,DOWN}. UP: shift left; on reaching bit NLED-1 go DOWN.
//       DOWN: shift right; on reaching bit 0 go UP. Exactly one bit set; end positions are not repeated
//       (NLED=4: 0001,0010,0100,1000,0100,0010,0001,0010...).
//     COUNT: r_pat <= r_pat+1 modulo 2**NLED (all-ones wraps to 0).
//   - w_mode changes between ticks take effect only at the next tick.
//  w_en=0: r_pat, r_mode, r_dir hold; w_tick ignored; w_led forced 0 next cycle; r_pwm keeps running.
//   A tick coincident with w_en falling is ignored.
//  PWM: r_pwm free-runs 0..2**DUTY_W-1 and wraps. r_duty loads w_duty only when r_pwm==max (glitch-free
//   update at period boundary). on = (r_duty==all-ones) | (r_pwm < r_duty).
//  Output: w_led <= (w_en & on) ? r_pat : 0, one register stage; pattern change visible on w_led
//   2 cycles after the tick (r_pat then w_led). w_step <= advance, visible 1 cycle after tick.
//  Widths: all arithmetic unsigned, truncated to NLED / DUTY_W; no saturation anywhere.
// STRUCTURE
//  Package led_seq_pkg: mode encodings (MODE_BLINK..MODE_COUNT), BOUNCE state encodings, seed function.
//  Sub-module m_pwm_gen (w_clk, w_rst_n, w_duty -> w_on): owns r_pwm, r_duty and the compare.
//  Top holds mode register, pattern register, bounce FSM and output register.
// TESTING
//  1 Reset: hold w_rst_n=0 with ticks/mode toggling -> w_led=0, w_step=0; release, duty=all-ones, BLINK,
//    ticks -> w_led 1111,0000,1111 on successive ticks; w_step one pulse per tick.
//  2 SHIFT NLED=4, duty all-ones, 6 ticks -> seed 0001 on mode-change tick, then 0010,0100,1000,0001,0010.
//  3 BOUNCE 8 ticks -> 0001,0010,0100,1000,0100,0010,0001,0010; never repeats 1000 or 0001 consecutively.
//  4 COUNT from 0, 17 ticks -> 0000..1111 then wraps to 0000 then 0001; mode change mid-run reseeds on next tick only.
//  5 PWM DUTY_W=8: duty 0 -> w_led never set; duty 64 -> on exactly 64 of 256 cycles; duty change
//    mid-period applies only after r_pwm wraps; duty 255 -> continuously on.
//  6 w_en=0 for 5 ticks in SHIFT at 0100 -> w_led=0, no w_step; w_en=1 -> resumes 0100 then 1000;
//    assert w_rst_n mid-pattern -> w_led=0 within the same cycle of reset assertion's propagation.

Source files
------------

// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_pkg
//  Purpose  : Shared encodings for the LED sequencer: pattern mode codes,
//             bounce-direction states and the per-mode seed description.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Seed is described width-independently as {fill_all, set_bit0} so the
  // caller can expand it to any LED count.
  function automatic logic [1:0] seed_code(input mode_e mode);
    logic [1:0] code;
    case (mode)
      MODE_BLINK:  code = 2'b10;
      MODE_SHIFT:  code = 2'b01;
      MODE_BOUNCE: code = 2'b01;
      default:     code = 2'b00;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_if
//  Purpose  : Control/status bundle between the tick source and the LED
//             sequencer.
//  Signals  : w_tick (step strobe), w_en (run), w_mode (pattern select),
//             w_duty (brightness), w_led (LED drive), w_step (advance pulse)
//  Revision : 1.0 - initial release
// ============================================================================
interface led_seq_if #(
  parameter int NLED   = 4,
  parameter int DUTY_W = 8
);
  logic              w_tick;
  logic              w_en;
  logic [1:0]        w_mode;
  logic [DUTY_W-1:0] w_duty;
  logic [NLED-1:0]   w_led;
  logic              w_step;

  modport master (output w_tick, w_en, w_mode, w_duty, input w_led, w_step);
  modport slave  (input w_tick, w_en, w_mode, w_duty, output w_led, w_step);
endinterface
`default_nettype wire

// File: rtl/m_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : m_pwm_gen
//  Purpose  : Free-running PWM compare. The duty value is captured only at
//             the end of each period so brightness changes never glitch.
//  Ports    : w_clk, w_rst_n (async active-low), w_duty (brightness),
//             w_on (combinational "LED lit" for the current cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module m_pwm_gen #(
  parameter int DUTY_W = 8
) (
  input  wire logic              w_clk,
  input  wire logic              w_rst_n,
  input  wire logic [DUTY_W-1:0] w_duty,
  output logic                   w_on
);

  logic [DUTY_W-1:0] r_pwm;
  logic [DUTY_W-1:0] r_duty;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pwm  <= '0;
      r_duty <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (r_pwm == '1) begin
        r_duty <= w_duty;
      end
    end
  end

  // All-ones is fully on; otherwise the compare alone would leave one dark
  // cycle per period.
  assign w_on = (r_duty == '1) | (r_pwm < r_duty);

endmodule
`default_nettype wire

// File: rtl/m_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : m_led_sequencer
//  Purpose  : Advances a selectable LED pattern (blink/shift/bounce/count)
//             once per divider tick and gates it with PWM brightness.
//  Ports    : w_clk, w_rst_n (async active-low),
//             bus (led_seq_if.slave): w_tick, w_en, w_mode, w_duty in;
//                                     w_led, w_step out (registered)
//  Params   : NLED (2..8), DUTY_W (PWM period 2**DUTY_W)
//  Revision : 1.0 - initial release
// ============================================================================
module m_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NLED   = 4,
  parameter int DUTY_W = 8
) (
  input  wire logic w_clk,
  input  wire logic w_rst_n,
  led_seq_if.slave  bus
);

  mode_e           r_mode;
  dir_e            r_dir;
  logic [NLED-1:0] r_pat;
  logic [NLED-1:0] r_led;
  logic            r_step;

  logic            w_on;
  logic            w_advance;
  mode_e           w_mode_req;
  logic [1:0]      w_seed_code;
  logic [NLED-1:0] w_seed;
  logic [NLED-1:0] w_shl;
  logic [NLED-1:0] w_shr;
  logic [NLED-1:0] w_rol;

  m_pwm_gen #(.DUTY_W(DUTY_W)) u_pwm (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_duty  (bus.w_duty),
    .w_on    (w_on)
  );

  // A tick while disabled (including the cycle enable drops) is discarded.
  assign w_advance   = bus.w_en & bus.w_tick;
  assign w_mode_req  = mode_e'(bus.w_mode);
  assign w_seed_code = seed_code(w_mode_req);
  assign w_seed      = {NLED{w_seed_code[1]}} | NLED'(w_seed_code[0]);
  assign w_shl       = r_pat << 1;
  assign w_shr       = r_pat >> 1;
  assign w_rol       = {r_pat[NLED-2:0], r_pat[NLED-1]};

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mode <= MODE_BLINK;
      r_dir  <= DIR_UP;
      r_pat  <= '0;
      r_led  <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_advance;
      r_led  <= (bus.w_en & w_on) ? r_pat : '0;
      if (w_advance) begin
        if (w_mode_req != r_mode) begin
          // Mode switch consumes the tick: load the new mode's seed.
          r_mode <= w_mode_req;
          r_pat  <= w_seed;
          r_dir  <= DIR_UP;
        end else begin
          case (r_mode)
            MODE_BLINK: r_pat <= ~r_pat;
            MODE_SHIFT: r_pat <= w_rol;
            MODE_BOUNCE: begin
              // Turn around on arrival at an end so that end position is
              // shown only once.
              if (r_dir == DIR_UP) begin
                r_pat <= w_shl;
                if (w_shl[NLED-1]) r_dir <= DIR_DOWN;
              end else begin
                r_pat <= w_shr;
                if (w_shr[0]) r_dir <= DIR_UP;
              end
            end
            default: r_pat <= r_pat + 1'b1;
          endcase
        end
      end
    end
  end

  assign bus.w_led  = r_led;
  assign bus.w_step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_m_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_led_sequencer
//  Purpose  : Directed self-checking bench for m_led_sequencer (NLED=4,
//             DUTY_W=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m_led_sequencer;

  localparam int NLED   = 4;
  localparam int DUTY_W = 8;

  logic w_clk;
  logic w_rst_n;
  int   checks;
  int   errors;

  led_seq_if #(.NLED(NLED), .DUTY_W(DUTY_W)) bus ();

  m_led_sequencer #(.NLED(NLED), .DUTY_W(DUTY_W)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge w_clk);
      #1;
    end
  endtask

  // One tick; returns w_step one cycle after and w_led two cycles after.
  task automatic do_tick(output logic step1, output logic [NLED-1:0] led2,
                         output logic step2);
    bus.w_tick = 1'b1;
    cyc(1);
    bus.w_tick = 1'b0;
    step1 = bus.w_step;
    cyc(1);
    led2  = bus.w_led;
    step2 = bus.w_step;
  endtask

  task automatic count_on(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (bus.w_led != '0) cnt++;
    end
  endtask

  task automatic test_reset();
    logic s1, s2;
    logic [NLED-1:0] l;
    logic [NLED-1:0] exp_blink [3];
    exp_blink = '{4'b1111, 4'b0000, 4'b1111};
    w_rst_n = 1'b0;
    bus.w_en = 1'b1;
    bus.w_duty = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      bus.w_tick = ~bus.w_tick;
      bus.w_mode = 2'(i);
      cyc(1);
      checks++;
      if (bus.w_led !== 4'b0000 || bus.w_step !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: led=%b step=%b required led=0000 step=0", bus.w_led, bus.w_step);
      end
    end
    w_rst_n = 1'b1;
    bus.w_tick = 1'b0;
    bus.w_mode = 2'd0;
    cyc(300);
    for (int i = 0; i < 3; i++) begin
      do_tick(s1, l, s2);
      checks++;
      if (l !== exp_blink[i] || s1 !== 1'b1 || s2 !== 1'b0) begin
        errors++;
        $display("FAIL blink_%0d: led=%b step=%b,%b required led=%b step=1,0", i, l, s1, s2, exp_blink[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic s1, s2;
    logic [NLED-1:0] l;
    logic [NLED-1:0] exp_sh [6];
    exp_sh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bus.w_mode = 2'd1;
    for (int i = 0; i < 6; i++) begin
      do_tick(s1, l, s2);
      checks++;
      if (l !== exp_sh[i] || s1 !== 1'b1) begin
        errors++;
        $display("FAIL shift_%0d: led=%b step=%b required led=%b step=1", i, l, s1, exp_sh[i]);
      end
    end
  endtask

  task automatic test_bounce();
    logic s1, s2;
    logic [NLED-1:0] l;
    logic [NLED-1:0] prev;
    logic [NLED-1:0] exp_b [8];
    exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    bus.w_mode = 2'd2;
    prev = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      do_tick(s1, l, s2);
      checks++;
      if (l !== exp_b[i] || l === prev) begin
        errors++;
        $display("FAIL bounce_%0d: led=%b prev=%b required led=%b", i, l, prev, exp_b[i]);
      end
      prev = l;
    end
  endtask

  task automatic test_count();
    logic s1, s2;
    logic [NLED-1:0] l;
    logic step_seen;
    bus.w_mode = 2'd3;
    for (int i = 0; i < 18; i++) begin
      do_tick(s1, l, s2);
      checks++;
      if (l !== 4'(i % 16)) begin
        errors++;
        $display("FAIL count_%0d: led=%b required %b", i, l, 4'(i % 16));
      end
    end
    // Mode request between ticks must not change anything until a tick.
    bus.w_mode = 2'd0;
    step_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (bus.w_step) step_seen = 1'b1;
    end
    checks++;
    if (bus.w_led !== 4'b0001 || step_seen !== 1'b0) begin
      errors++;
      $display("FAIL count_mode_hold: led=%b step_seen=%b required led=0001 step_seen=0", bus.w_led, step_seen);
    end
    do_tick(s1, l, s2);
    checks++;
    if (l !== 4'b1111 || s1 !== 1'b1) begin
      errors++;
      $display("FAIL count_reseed: led=%b step=%b required led=1111 step=1", l, s1);
    end
  endtask

  task automatic test_pwm();
    int cnt;
    int waited;
    logic prev_on;
    bus.w_duty = 8'd0;
    cyc(300);
    count_on(256, cnt);
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL pwm_duty0: on_cycles=%0d required 0", cnt);
    end
    bus.w_duty = 8'd64;
    cyc(300);
    count_on(256, cnt);
    checks++;
    if (cnt != 64) begin
      errors++;
      $display("FAIL pwm_duty64: on_cycles=%0d required 64", cnt);
    end
    // Find the start of a lit interval (period start), then change duty mid-period.
    prev_on = 1'b1;
    waited = 0;
    while (!(bus.w_led != '0 && !prev_on) && waited < 600) begin
      prev_on = (bus.w_led != '0);
      cyc(1);
      waited++;
    end
    checks++;
    if (waited >= 600) begin
      errors++;
      $display("FAIL pwm_edge_timeout: waited=%0d cycles required <600", waited);
    end
    cyc(100);
    bus.w_duty = 8'd192;
    count_on(100, cnt);
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL pwm_midperiod: on_cycles=%0d required 0", cnt);
    end
    count_on(256, cnt);
    checks++;
    if (cnt != 192) begin
      errors++;
      $display("FAIL pwm_duty192: on_cycles=%0d required 192", cnt);
    end
    bus.w_duty = 8'hFF;
    cyc(300);
    count_on(256, cnt);
    checks++;
    if (cnt != 256) begin
      errors++;
      $display("FAIL pwm_duty255: on_cycles=%0d required 256", cnt);
    end
  endtask

  task automatic test_enable();
    logic s1, s2;
    logic [NLED-1:0] l;
    logic bad;
    bus.w_mode = 2'd1;
    for (int i = 0; i < 3; i++) do_tick(s1, l, s2);
    checks++;
    if (l !== 4'b0100) begin
      errors++;
      $display("FAIL en_setup: led=%b required 0100", l);
    end
    // First disabled tick coincides with enable falling.
    bus.w_en = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_tick(s1, l, s2);
      if (s1 !== 1'b0 || s2 !== 1'b0 || l !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || bus.w_led !== 4'b0000) begin
      errors++;
      $display("FAIL en_off: led=%b bad=%b required led=0000 bad=0", bus.w_led, bad);
    end
    bus.w_en = 1'b1;
    cyc(1);
    checks++;
    if (bus.w_led !== 4'b0100) begin
      errors++;
      $display("FAIL en_resume: led=%b required 0100", bus.w_led);
    end
    do_tick(s1, l, s2);
    checks++;
    if (l !== 4'b1000 || s1 !== 1'b1) begin
      errors++;
      $display("FAIL en_next: led=%b step=%b required led=1000 step=1", l, s1);
    end
    w_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.w_led !== 4'b0000 || bus.w_step !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: led=%b step=%b required led=0000 step=0", bus.w_led, bus.w_step);
    end
    cyc(2);
    w_rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    w_rst_n = 1'b0;
    bus.w_tick = 1'b0;
    bus.w_en = 1'b0;
    bus.w_mode = 2'd0;
    bus.w_duty = '0;
    cyc(1);
    test_reset();
    test_shift();
    test_bounce();
    test_count();
    test_pwm();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
